// File: rtl/cache_control_wb.sv
// N-way write-back, write-allocate cache controller FSM.
// Drives the tag/valid/dirty/data array strobes, the pmem burst handshake and the saturating hit/miss/writeback counters.
module cache_control_wb #(
  parameter int NUM_WAYS = 4,
  parameter int WAY_W    = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1,
  parameter int CNT_W    = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                mem_read,
  input  logic                mem_write,
  output logic                mem_resp,
  input  logic [NUM_WAYS-1:0] hit_way,
  input  logic [WAY_W-1:0]    victim_way,
  input  logic                victim_valid,
  input  logic                victim_dirty,
  output logic                pmem_read,
  output logic                pmem_write,
  input  logic                pmem_resp,
  output logic                pmem_addr_sel,
  output logic                data_in_sel,
  output logic [NUM_WAYS-1:0] load_data,
  output logic [NUM_WAYS-1:0] load_tag,
  output logic [NUM_WAYS-1:0] set_valid,
  output logic [NUM_WAYS-1:0] set_dirty,
  output logic [NUM_WAYS-1:0] clr_dirty,
  output logic                load_lru,
  output logic [CNT_W-1:0]    hit_count,
  output logic [CNT_W-1:0]    miss_count,
  output logic [CNT_W-1:0]    wb_count
);

  typedef enum logic [1:0] {IDLE, CHECK, WRITEBACK, ALLOCATE} state_e;

  state_e              state_q, state_d;
  logic [WAY_W-1:0]    vway_q, vway_d;
  logic [CNT_W-1:0]    hit_count_q, hit_count_d;
  logic [CNT_W-1:0]    miss_count_q, miss_count_d;
  logic [CNT_W-1:0]    wb_count_q, wb_count_d;
  logic [NUM_WAYS-1:0] vway_oh;
  logic                req;
  logic                is_write;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // A simultaneous read and write is served as a read.
  assign req      = mem_read | mem_write;
  assign is_write = mem_write & ~mem_read;
  assign vway_oh  = NUM_WAYS'(1) << vway_q;

  assign hit_count  = hit_count_q;
  assign miss_count = miss_count_q;
  assign wb_count   = wb_count_q;

  always_comb begin
    state_d       = state_q;
    vway_d        = vway_q;
    hit_count_d   = hit_count_q;
    miss_count_d  = miss_count_q;
    wb_count_d    = wb_count_q;
    mem_resp      = 1'b0;
    pmem_read     = 1'b0;
    pmem_write    = 1'b0;
    pmem_addr_sel = 1'b0;
    data_in_sel   = 1'b0;
    load_data     = '0;
    load_tag      = '0;
    set_valid     = '0;
    set_dirty     = '0;
    clr_dirty     = '0;
    load_lru      = 1'b0;

    case (state_q)
      IDLE: begin
        if (req) state_d = CHECK;
      end
      CHECK: begin
        if (!req) begin
          state_d = IDLE;
        end else if (|hit_way) begin
          mem_resp    = 1'b1;
          load_lru    = 1'b1;
          hit_count_d = sat_inc(hit_count_q);
          if (is_write) begin
            load_data = hit_way;
            set_dirty = hit_way;
          end
          state_d = IDLE;
        end else begin
          miss_count_d = sat_inc(miss_count_q);
          vway_d       = (NUM_WAYS == 1) ? '0 : victim_way;
          state_d      = (victim_valid & victim_dirty) ? WRITEBACK : ALLOCATE;
        end
      end
      WRITEBACK: begin
        pmem_write    = 1'b1;
        pmem_addr_sel = 1'b1;
        if (pmem_resp) begin
          clr_dirty  = vway_oh;
          wb_count_d = sat_inc(wb_count_q);
          state_d    = ALLOCATE;
        end
      end
      ALLOCATE: begin
        pmem_read = 1'b1;
        // The refilled line is re-checked so the pending access is served as a hit.
        if (pmem_resp) begin
          load_data   = vway_oh;
          load_tag    = vway_oh;
          set_valid   = vway_oh;
          clr_dirty   = vway_oh;
          data_in_sel = 1'b1;
          state_d     = CHECK;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= IDLE;
      vway_q       <= '0;
      hit_count_q  <= '0;
      miss_count_q <= '0;
      wb_count_q   <= '0;
    end else begin
      state_q      <= state_d;
      vway_q       <= vway_d;
      hit_count_q  <= hit_count_d;
      miss_count_q <= miss_count_d;
      wb_count_q   <= wb_count_d;
    end
  end

endmodule

// File: tb/tb_cache_control_wb.sv
// Bench for cache_control_wb: plays datapath and pmem, predicts each CPU access
// from a line-level cache model, and watches a second 2-bit-counter instance for saturation.
`timescale 1ns/1ps
module tb_cache_control_wb;
  localparam int NW = 4;
  localparam int WW = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, mem_read, mem_write, pmem_resp, victim_valid, victim_dirty;
  logic [NW-1:0] hit_way;
  logic [WW-1:0] victim_way;
  logic          mem_resp, pmem_read, pmem_write, pmem_addr_sel, data_in_sel, load_lru;
  logic [NW-1:0] load_data, load_tag, set_valid, set_dirty, clr_dirty;
  logic [31:0]   hit_count, miss_count, wb_count;
  logic          d2_mem_resp, d2_pmem_read, d2_pmem_write, d2_pmem_addr_sel, d2_data_in_sel, d2_load_lru;
  logic [NW-1:0] d2_load_data, d2_load_tag, d2_set_valid, d2_set_dirty, d2_clr_dirty;
  logic [1:0]    d2_hit_count, d2_miss_count, d2_wb_count;

  cache_control_wb #(.NUM_WAYS(NW), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write), .mem_resp(mem_resp),
    .hit_way(hit_way), .victim_way(victim_way), .victim_valid(victim_valid), .victim_dirty(victim_dirty),
    .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_resp(pmem_resp), .pmem_addr_sel(pmem_addr_sel),
    .data_in_sel(data_in_sel), .load_data(load_data), .load_tag(load_tag), .set_valid(set_valid),
    .set_dirty(set_dirty), .clr_dirty(clr_dirty), .load_lru(load_lru),
    .hit_count(hit_count), .miss_count(miss_count), .wb_count(wb_count));

  cache_control_wb #(.NUM_WAYS(NW), .CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write), .mem_resp(d2_mem_resp),
    .hit_way(hit_way), .victim_way(victim_way), .victim_valid(victim_valid), .victim_dirty(victim_dirty),
    .pmem_read(d2_pmem_read), .pmem_write(d2_pmem_write), .pmem_resp(pmem_resp), .pmem_addr_sel(d2_pmem_addr_sel),
    .data_in_sel(d2_data_in_sel), .load_data(d2_load_data), .load_tag(d2_load_tag), .set_valid(d2_set_valid),
    .set_dirty(d2_set_dirty), .clr_dirty(d2_clr_dirty), .load_lru(d2_load_lru),
    .hit_count(d2_hit_count), .miss_count(d2_miss_count), .wb_count(d2_wb_count));

  // Datapath image, updated only through the DUT's array strobes
  logic [7:0] tag_a [NW];
  logic       val_a [NW];
  logic       dty_a [NW];
  // Reference model of the cache contents and counters
  logic [7:0] m_tag [NW];
  logic       m_val [NW];
  logic       m_dty [NW];
  int hits, misses, wbs;

  logic [7:0] cur_tag;
  int vict, wb_d, fill_d, pcnt;
  logic xfer;
  int checks, errors;

  int n_resp, resp_i, n_pr, n_pw, n_both, n_selbad, n_clr, n_ld, n_sd, n_lt;
  bit lru_bad;
  logic [NW-1:0] fill_ld, fill_tag, fill_val, merge_ld, merge_sd;
  logic fill_sel, merge_sel;

  function automatic logic [NW-1:0] oh(input int k);
    logic [NW-1:0] r;
    r = '0;
    r[k] = 1'b1;
    return r;
  endfunction

  function automatic logic [1:0] sat2(input int x);
    return (x > 3) ? 2'd3 : 2'(x);
  endfunction

  task automatic clr_acc();
    n_resp = 0; resp_i = -1; n_pr = 0; n_pw = 0; n_both = 0; n_selbad = 0;
    n_clr = 0; n_ld = 0; n_sd = 0; n_lt = 0; lru_bad = 0;
    fill_ld = '0; fill_tag = '0; fill_val = '0; fill_sel = 1'b0;
    merge_ld = '0; merge_sd = '0; merge_sel = 1'b1;
  endtask

  // Drive one cycle's inputs at the falling edge, sample outputs, apply array writes.
  task automatic cyc_pre(input int i);
    hit_way = '0;
    for (int k = 0; k < NW; k++) if (val_a[k] && tag_a[k] == cur_tag) hit_way[k] = 1'b1;
    victim_way   = WW'(vict);
    victim_valid = val_a[vict];
    victim_dirty = dty_a[vict];
    xfer = pmem_read | pmem_write;
    if (xfer) begin
      pcnt++;
      pmem_resp = (pcnt >= (pmem_write ? wb_d : fill_d));
    end else begin
      pmem_resp = 1'($urandom_range(0, 1));
    end
    #1;
    checks++;
    if (!$onehot0(hit_way)) begin
      errors++;
      $display("FAIL onehot0_hit_way: hit_way=%b, required at most one bit set", hit_way);
    end
    if (mem_resp) begin n_resp++; resp_i = i; end
    if (load_lru != mem_resp) lru_bad = 1;
    if (pmem_read) n_pr++;
    if (pmem_write) n_pw++;
    if (pmem_read && pmem_write) n_both++;
    if (pmem_addr_sel != pmem_write) n_selbad++;
    n_clr += $countones(clr_dirty);
    if (set_dirty != '0) n_sd++;
    if ((load_tag | set_valid) != '0) n_lt++;
    if (load_data != '0) begin
      n_ld++;
      if (pmem_read) begin
        fill_ld = load_data; fill_tag = load_tag; fill_val = set_valid; fill_sel = data_in_sel;
      end else begin
        merge_ld = load_data; merge_sd = set_dirty; merge_sel = data_in_sel;
      end
    end
    for (int k = 0; k < NW; k++) begin
      if (load_tag[k])  tag_a[k] = cur_tag;
      if (set_valid[k]) val_a[k] = 1'b1;
      if (clr_dirty[k]) dty_a[k] = 1'b0;
      if (set_dirty[k]) dty_a[k] = 1'b1;
    end
  endtask

  task automatic cyc_post();
    @(posedge clk);
    if (xfer && pmem_resp) pcnt = 0;
    @(negedge clk);
  endtask

  task automatic check_counters(input string tag_s);
    checks++;
    if (hit_count !== 32'(hits) || miss_count !== 32'(misses) || wb_count !== 32'(wbs)) begin
      errors++;
      $display("FAIL counters_%s: got h/m/w=%0d/%0d/%0d, required %0d/%0d/%0d",
               tag_s, hit_count, miss_count, wb_count, hits, misses, wbs);
    end
    checks++;
    if (d2_hit_count !== sat2(hits) || d2_miss_count !== sat2(misses) || d2_wb_count !== sat2(wbs)) begin
      errors++;
      $display("FAIL sat_counters_%s: got h/m/w=%0d/%0d/%0d, required %0d/%0d/%0d", tag_s,
               d2_hit_count, d2_miss_count, d2_wb_count, sat2(hits), sat2(misses), sat2(wbs));
    end
  endtask

  task automatic check_arrays(input string tag_s);
    logic [NW-1:0] av, ad, mv, md;
    logic [8*NW-1:0] at, mt;
    for (int k = 0; k < NW; k++) begin
      av[k] = val_a[k]; ad[k] = dty_a[k] & val_a[k];
      mv[k] = m_val[k]; md[k] = m_dty[k] & m_val[k];
      at[8*k +: 8] = val_a[k] ? tag_a[k] : 8'h00;
      mt[8*k +: 8] = m_val[k] ? m_tag[k] : 8'h00;
    end
    checks++;
    if (av !== mv || ad !== md || at !== mt) begin
      errors++;
      $display("FAIL lines_%s: got valid=%b dirty=%b tags=%h, required valid=%b dirty=%b tags=%h",
               tag_s, av, ad, at, mv, md, mt);
    end
  endtask

  // op: 0 read, 1 write, 2 read and write together (served as read)
  task automatic run_txn(input int op, input logic [7:0] tag, input int v, input int wd,
                         input int fd, input bit drop_req, input string name);
    int line, wbn, eresp;
    bit miss, ewb, drop, wr_served;
    line = -1;
    for (int k = 0; k < NW; k++) if (m_val[k] && m_tag[k] == tag) line = k;
    miss  = (line < 0);
    ewb   = miss && m_val[v] && m_dty[v];
    wbn   = ewb ? wd : 0;
    eresp = miss ? 2 + wbn + fd : 1;
    drop  = drop_req && miss;
    wr_served = (op == 1) && !drop;
    cur_tag = tag; vict = v; wb_d = wd; fill_d = fd; pcnt = 0;
    clr_acc();
    mem_read  = (op != 1);
    mem_write = (op != 0);
    for (int i = 0; i < 80; i++) begin
      cyc_pre(i);
      if (drop && i == 2 + wbn) begin mem_read = 1'b0; mem_write = 1'b0; end
      cyc_post();
      if (!drop && n_resp > 0) break;
      if (drop && i >= eresp + 1) break;
    end
    mem_read = 1'b0; mem_write = 1'b0;

    if (miss) begin
      misses++;
      if (ewb) wbs++;
      m_tag[v] = tag; m_val[v] = 1'b1; m_dty[v] = wr_served;
      if (!drop) hits++;
      line = v;
    end else begin
      hits++;
      if (op == 1) m_dty[line] = 1'b1;
    end

    checks++;
    if (n_resp != (drop ? 0 : 1)) begin
      errors++;
      $display("FAIL %s_resp_count: got %0d mem_resp pulses, required %0d", name, n_resp, drop ? 0 : 1);
    end
    if (!drop) begin
      checks++;
      if (resp_i != eresp) begin
        errors++;
        $display("FAIL %s_latency: mem_resp at cycle %0d, required %0d", name, resp_i, eresp);
      end
    end
    checks++;
    if (n_pw != wbn || n_pr != (miss ? fd : 0)) begin
      errors++;
      $display("FAIL %s_pmem_cycles: got write=%0d read=%0d, required write=%0d read=%0d",
               name, n_pw, n_pr, wbn, miss ? fd : 0);
    end
    checks++;
    if (n_both != 0 || n_selbad != 0) begin
      errors++;
      $display("FAIL %s_pmem_strobes: got both_high=%0d addr_sel_wrong=%0d, required 0/0", name, n_both, n_selbad);
    end
    checks++;
    if (n_clr != (miss ? (ewb ? 2 : 1) : 0)) begin
      errors++;
      $display("FAIL %s_clr_dirty: got %0d pulses, required %0d", name, n_clr, miss ? (ewb ? 2 : 1) : 0);
    end
    checks++;
    if (n_ld != int'(miss) + int'(wr_served) || n_sd != int'(wr_served) || n_lt != int'(miss)) begin
      errors++;
      $display("FAIL %s_strobe_counts: got load_data=%0d set_dirty=%0d tag/valid=%0d, required %0d/%0d/%0d",
               name, n_ld, n_sd, n_lt, int'(miss) + int'(wr_served), int'(wr_served), int'(miss));
    end
    if (miss) begin
      checks++;
      if ({fill_ld, fill_tag, fill_val, fill_sel} !== {oh(v), oh(v), oh(v), 1'b1}) begin
        errors++;
        $display("FAIL %s_fill: got ld=%b tag=%b val=%b sel=%b, required %b on all with sel=1",
                 name, fill_ld, fill_tag, fill_val, fill_sel, oh(v));
      end
    end
    if (wr_served) begin
      checks++;
      if ({merge_ld, merge_sd, merge_sel} !== {oh(line), oh(line), 1'b0}) begin
        errors++;
        $display("FAIL %s_write_merge: got ld=%b set_dirty=%b sel=%b, required %b/%b/0",
                 name, merge_ld, merge_sd, merge_sel, oh(line), oh(line));
      end
    end
    checks++;
    if (lru_bad) begin
      errors++;
      $display("FAIL %s_load_lru: got load_lru not matching mem_resp, required equal every cycle", name);
    end
    check_counters(name);
    check_arrays(name);
  endtask

  task automatic test_reset();
    rst = 1'b0; mem_read = 1'b1; mem_write = 1'b0; pmem_resp = 1'b1;
    hit_way = 4'b0100; victim_way = '0; victim_valid = 1'b1; victim_dirty = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({mem_resp, pmem_read, pmem_write, pmem_addr_sel, data_in_sel, load_lru,
         load_data, load_tag, set_valid, set_dirty, clr_dirty} !== 26'd0) begin
      errors++;
      $display("FAIL reset_outputs: got mem_resp=%b pmem_r/w=%b%b load_data=%b, required all zero",
               mem_resp, pmem_read, pmem_write, load_data);
    end
    check_counters("reset");
    mem_read = 1'b0; pmem_resp = 1'b0; hit_way = '0;
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_directed();
    run_txn(0, 8'hA0, 2, 1, 2, 1'b0, "prep_fill");
    run_txn(0, 8'hB0, 3, 1, 5, 1'b0, "clean_read_miss");
    run_txn(0, 8'hA0, 0, 1, 1, 1'b0, "read_hit");
    run_txn(1, 8'hA0, 0, 1, 1, 1'b0, "write_hit");
    run_txn(1, 8'hC0, 1, 3, 3, 1'b0, "clean_write_miss");
    run_txn(1, 8'hC1, 1, 3, 3, 1'b0, "dirty_write_miss");
    run_txn(2, 8'hB0, 0, 1, 1, 1'b0, "both_req_hit");
  endtask

  task automatic test_drop();
    run_txn(0, 8'hD0, 1, 2, 4, 1'b1, "drop_dirty_miss");
    run_txn(1, 8'hD1, 0, 2, 3, 1'b1, "drop_write_miss");
  endtask

  task automatic test_reset_mid_miss();
    bit ewb;
    int bad;
    ewb = m_val[0] && m_dty[0];
    cur_tag = 8'hEE; vict = 0; wb_d = 1; fill_d = 1000; pcnt = 0;
    clr_acc();
    mem_read = 1'b1; mem_write = 1'b0;
    for (int i = 0; i < 20 && n_pr < 2; i++) begin
      cyc_pre(i);
      cyc_post();
    end
    checks++;
    if (n_pr < 2) begin
      errors++;
      $display("FAIL reset_mid_reach_allocate: got %0d pmem_read cycles, required 2", n_pr);
    end
    rst = 1'b0; mem_read = 1'b0; pmem_resp = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (pmem_read !== 1'b0 || pmem_write !== 1'b0 || mem_resp !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_outputs: got pmem_read=%b pmem_write=%b mem_resp=%b, required 0/0/0",
               pmem_read, pmem_write, mem_resp);
    end
    if (ewb) m_dty[0] = 1'b0;
    hits = 0; misses = 0; wbs = 0;
    check_counters("reset_mid");
    rst = 1'b1;
    bad = 0;
    repeat (3) begin
      @(negedge clk);
      if (mem_resp || pmem_read || pmem_write) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL reset_mid_quiet: got %0d active cycles after reset, required 0", bad);
    end
    check_arrays("reset_mid");
  endtask

  task automatic test_saturation();
    for (int n = 0; n < 5; n++) run_txn(0, 8'hA0, 0, 1, 1, 1'b0, "sat_hit");
    checks++;
    if (d2_hit_count !== 2'd3 || hit_count !== 32'd5) begin
      errors++;
      $display("FAIL saturation: got hit_count=%0d (2-bit %0d), required 5 (2-bit 3)", hit_count, d2_hit_count);
    end
  endtask

  task automatic test_back_to_back();
    for (int n = 0; n < 40; n++)
      run_txn(int'($urandom_range(0, 2)), 8'($urandom_range(0, 7)), int'($urandom_range(0, 3)),
              int'($urandom_range(1, 4)), int'($urandom_range(1, 4)), $urandom_range(0, 5) == 0, "random");
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0; errors = 0; hits = 0; misses = 0; wbs = 0;
    for (int k = 0; k < NW; k++) begin
      tag_a[k] = 8'h00; val_a[k] = 1'b0; dty_a[k] = 1'b0;
      m_tag[k] = 8'h00; m_val[k] = 1'b0; m_dty[k] = 1'b0;
    end
    test_reset();
    test_directed();
    test_drop();
    test_reset_mid_miss();
    test_saturation();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cache_control_wb.md
Name: cache_control_wb

Overview:
- Parametrised N-way, write-back, write-allocate cache controller FSM.
- Successor to the single-way read-only cache controller.
- Sits between the CPU-side mem_* handshake and the cache datapath (tag/valid/dirty/data arrays) plus the pmem_* burst interface.
- Adds dirty-victim writeback, way-select control, hit/miss/writeback counters, and defined behaviour for dropped requests.

Parameters:
- NUM_WAYS, 4, associativity; power of two, >= 1.
- WAY_W, $clog2(NUM_WAYS) (minimum 1), victim-index width.
- CNT_W, 32, width of the saturating performance counters.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-low (0 = reset)
- mem_read  in  1  CPU read request, held until mem_resp
- mem_write  in  1  CPU write request, held until mem_resp
- mem_resp  out  1  one-cycle completion pulse to CPU
- hit_way  in  NUM_WAYS  per-way tag-match & valid from datapath, onehot0
- victim_way  in  WAY_W  way chosen by replacement logic for current set
- victim_valid  in  1  valid bit of victim line
- victim_dirty  in  1  dirty bit of victim line
- pmem_read  out  1  line-fill request
- pmem_write  out  1  line-writeback request
- pmem_resp  in  1  pmem transfer complete
- pmem_addr_sel  out  1  0 = CPU address, 1 = victim tag address
- data_in_sel  out  1  0 = CPU write data (byte-enabled), 1 = pmem line
- load_data  out  NUM_WAYS  data-array write enable per way
- load_tag  out  NUM_WAYS  tag-array write enable per way
- set_valid  out  NUM_WAYS  set valid bit per way
- set_dirty  out  NUM_WAYS  set dirty bit per way
- clr_dirty  out  NUM_WAYS  clear dirty bit per way
- load_lru  out  1  update replacement state with hit way
- hit_count  out  CNT_W  hits since reset
- miss_count  out  CNT_W  misses since reset
- wb_count  out  CNT_W  writebacks since reset

Behaviour:
- States: IDLE, CHECK, WRITEBACK, ALLOCATE.
- All outputs are combinational from state and inputs, except the counters and the latched victim register (vway, WAY_W bits). Every output not named in a state is 0.
- Reset: rst==0 at a clk edge forces state=IDLE, vway=0, all counters=0. In IDLE all control outputs are 0. Reset mid-miss drops pmem_read/pmem_write in the cycle after the edge; no mem_resp is issued.
- IDLE: mem_read|mem_write -> CHECK. If both are high, treat as read.
- CHECK, hit (|hit_way):
  - mem_resp=1, load_lru=1, hit_count++.
  - On write: additionally load_data=hit_way, set_dirty=hit_way, data_in_sel=0.
  - Next state IDLE.
- CHECK, miss, request still asserted:
  - miss_count++, vway<=victim_way.
  - victim_valid&victim_dirty -> WRITEBACK; otherwise -> ALLOCATE.
- CHECK, neither request asserted (CPU dropped request): -> IDLE; no mem_resp, no counter change.
- WRITEBACK:
  - pmem_write=1, pmem_addr_sel=1; hold until pmem_resp.
  - On pmem_resp: clr_dirty[vway]=1, wb_count++, -> ALLOCATE.
- ALLOCATE:
  - pmem_read=1, pmem_addr_sel=0; hold until pmem_resp.
  - On pmem_resp: load_data[vway], load_tag[vway], set_valid[vway], clr_dirty[vway]=1, data_in_sel=1, -> CHECK.
  - Re-CHECK then hits and serves the request, including a write merge. A refill counts as a hit in hit_count.
- pmem_resp in IDLE/CHECK is ignored.
- pmem_read and pmem_write are never high together.
- Latency: hit mem_resp 1 cycle after request seen in IDLE. Clean miss: mem_resp 1 cycle after fill pmem_resp. Dirty miss adds the writeback duration.
- Counters saturate at {CNT_W{1'b1}}; no wrap.
- Request dropped mid-miss: the fill/writeback completes, then CHECK -> IDLE without mem_resp.
- hit_way with >1 bit set is illegal. The bench asserts onehot0; RTL behaviour is undefined.
- NUM_WAYS=1: victim_way is ignored; vway=0.

Test Plan:
- Read hit, hit_way=4'b0100 -> mem_resp 1 cycle after IDLE sees request; load_lru=1; hit_count 0->1; no pmem activity.
- Write hit on way 2 -> load_data=set_dirty=4'b0100, data_in_sel=0, mem_resp same cycle.
- Clean read miss, victim_way=3, victim_dirty=0, pmem_resp after 5 cycles -> pmem_read high 5 cycles; load_data/load_tag/set_valid=4'b1000; re-CHECK hit -> mem_resp; miss_count=1, wb_count=0.
- Dirty write miss, victim_way=1, pmem_resp after 3 cycles each -> pmem_write with pmem_addr_sel=1 then pmem_read; clr_dirty=4'b0010 twice; final write sets set_dirty=4'b0010; wb_count=1, never both pmem strobes high.
- rst=0 during ALLOCATE -> next cycle IDLE, pmem_read=0, counters=0, no mem_resp; CNT_W=2 with 5 hits -> hit_count=3 (saturated).
- Drop mem_read during ALLOCATE -> fill completes, CHECK -> IDLE, mem_resp never asserted.
